// File: rtl/sad_fsbm_engine.sv
// Full-search block-matching SAD engine: saturating per-candidate SAD over ROWS beats of
// LANES pixel pairs, with running-minimum tracking across NCAND candidates.
module sad_fsbm_engine #(
    parameter int LANES = 16,
    parameter int PIX_W = 8,
    parameter int ROWS  = 16,
    parameter int NCAND = 256,
    parameter int SAD_W = 32,
    parameter int IDX_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   abort,
    input  logic [LANES*PIX_W-1:0] cur_pix,
    input  logic [LANES*PIX_W-1:0] ref_pix,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   sad_valid,
    output logic [SAD_W-1:0]       sad_out,
    output logic [IDX_W-1:0]       cand_idx,
    output logic [SAD_W-1:0]       best_sad,
    output logic [IDX_W-1:0]       best_idx,
    output logic                   done
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NCAND - 1);

    typedef enum logic [1:0] {IDLE, INIT, ACC, CEND} state_t;

    state_t           state_q;
    logic [SAD_W-1:0] sum_q;
    logic [SAD_W-1:0] sum_d;
    logic [SAD_W-1:0] beat_sad;
    logic [SAD_W:0]   sum_ext;
    logic [SAD_W-1:0] sad_q;
    logic [SAD_W-1:0] best_q;
    logic [ROW_W-1:0] row_q;
    logic [IDX_W-1:0] cand_q;
    logic [IDX_W-1:0] cidx_q;
    logic [IDX_W-1:0] bidx_q;
    logic             sv_q;
    logic             done_q;
    logic [PIX_W-1:0] lane_diff [LANES];

    // Compare-then-subtract keeps the magnitude unsigned, so ref > cur never wraps.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PIX_W-1:0] c_pix;
            logic [PIX_W-1:0] r_pix;
            assign c_pix         = cur_pix[gi*PIX_W +: PIX_W];
            assign r_pix         = ref_pix[gi*PIX_W +: PIX_W];
            assign lane_diff[gi] = (c_pix >= r_pix) ? (c_pix - r_pix) : (r_pix - c_pix);
        end
    endgenerate

    always_comb begin
        beat_sad = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sad = beat_sad + SAD_W'(lane_diff[i]);
        end
    end

    // The extra carry bit flags overflow; once pinned at all ones the sum can only stay there.
    assign sum_ext = {1'b0, sum_q} + {1'b0, beat_sad};
    assign sum_d   = sum_ext[SAD_W] ? '1 : sum_ext[SAD_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            row_q   <= '0;
            cand_q  <= '0;
            sad_q   <= '0;
            cidx_q  <= '0;
            best_q  <= '1;
            bidx_q  <= '0;
            sv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sv_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go) state_q <= INIT;
                end
                INIT: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        sum_q   <= '0;
                        row_q   <= '0;
                        cand_q  <= '0;
                        best_q  <= '1;
                        bidx_q  <= '0;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (in_valid) begin
                        sum_q <= sum_d;
                        if (row_q == ROW_LAST) begin
                            row_q   <= '0;
                            state_q <= CEND;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                CEND: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        sad_q  <= sum_q;
                        cidx_q <= cand_q;
                        sv_q   <= 1'b1;
                        // Strict compare: on a tie the earlier candidate keeps the slot.
                        if (sum_q < best_q) begin
                            best_q <= sum_q;
                            bidx_q <= cand_q;
                        end
                        if (cand_q == CAND_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cand_q  <= cand_q + 1'b1;
                            sum_q   <= '0;
                            state_q <= ACC;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACC);
    assign busy      = (state_q != IDLE);
    assign sad_valid = sv_q;
    assign done      = done_q;
    assign sad_out   = sad_q;
    assign cand_idx  = cidx_q;
    assign best_sad  = best_q;
    assign best_idx  = bidx_q;
endmodule

// File: tb/tb_sad_fsbm_engine.sv
// Bench for sad_fsbm_engine: three instances (4-candidate, 12-bit saturating, 1x1x1) checked
// against an arithmetic SAD/min model of each search.
`timescale 1ns/1ps
module tb_sad_fsbm_engine;
    localparam int ROWS  = 16;
    localparam int LANES = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic         abort = 1'b0;
    logic         valid = 1'b0;
    int           sel = 0;
    logic [127:0] cur_bus = '0;
    logic [127:0] ref_bus = '0;

    logic        rdy_a, busy_a, sv_a, done_a;
    logic [31:0] sad_a, best_a;
    logic [7:0]  ci_a, bi_a;
    logic        rdy_b, busy_b, sv_b, done_b;
    logic [11:0] sad_b, best_b;
    logic [7:0]  ci_b, bi_b;
    logic        rdy_c, busy_c, sv_c, done_c;
    logic [31:0] sad_c, best_c;
    logic [7:0]  ci_c, bi_c;

    sad_fsbm_engine #(.LANES(16), .PIX_W(8), .ROWS(16), .NCAND(4), .SAD_W(32), .IDX_W(8)) u_a (
        .clk(clk), .rst(rst), .go(go && sel == 0), .abort(abort && sel == 0),
        .cur_pix(cur_bus), .ref_pix(ref_bus), .in_valid(valid && sel == 0),
        .in_ready(rdy_a), .busy(busy_a), .sad_valid(sv_a), .sad_out(sad_a),
        .cand_idx(ci_a), .best_sad(best_a), .best_idx(bi_a), .done(done_a));

    sad_fsbm_engine #(.LANES(16), .PIX_W(8), .ROWS(16), .NCAND(1), .SAD_W(12), .IDX_W(8)) u_b (
        .clk(clk), .rst(rst), .go(go && sel == 1), .abort(abort && sel == 1),
        .cur_pix(cur_bus), .ref_pix(ref_bus), .in_valid(valid && sel == 1),
        .in_ready(rdy_b), .busy(busy_b), .sad_valid(sv_b), .sad_out(sad_b),
        .cand_idx(ci_b), .best_sad(best_b), .best_idx(bi_b), .done(done_b));

    sad_fsbm_engine #(.LANES(1), .PIX_W(8), .ROWS(1), .NCAND(1), .SAD_W(32), .IDX_W(8)) u_c (
        .clk(clk), .rst(rst), .go(go && sel == 2), .abort(abort && sel == 2),
        .cur_pix(cur_bus[7:0]), .ref_pix(ref_bus[7:0]), .in_valid(valid && sel == 2),
        .in_ready(rdy_c), .busy(busy_c), .sad_valid(sv_c), .sad_out(sad_c),
        .cand_idx(ci_c), .best_sad(best_c), .best_idx(bi_c), .done(done_c));

    logic        obs_ready, obs_busy, obs_sv, obs_done;
    logic [31:0] obs_sad, obs_best;
    logic [7:0]  obs_ci, obs_bi;

    always_comb begin
        obs_ready = rdy_a; obs_busy = busy_a; obs_sv = sv_a; obs_done = done_a;
        obs_sad = sad_a; obs_best = best_a; obs_ci = ci_a; obs_bi = bi_a;
        if (sel == 1) begin
            obs_ready = rdy_b; obs_busy = busy_b; obs_sv = sv_b; obs_done = done_b;
            obs_sad = 32'(sad_b); obs_best = 32'(best_b); obs_ci = ci_b; obs_bi = bi_b;
        end else if (sel == 2) begin
            obs_ready = rdy_c; obs_busy = busy_c; obs_sv = sv_c; obs_done = done_c;
            obs_sad = sad_c; obs_best = best_c; obs_ci = ci_c; obs_bi = bi_c;
        end
    end

    logic [127:0] cur_mem [4][ROWS];
    logic [127:0] ref_mem [4][ROWS];

    int     n_cmp = 0;
    int     n_fail = 0;
    longint best_m, last_sad_m;
    int     bidx_m, last_idx_m;

    function automatic int rows_n();  return (sel == 2) ? 1 : ROWS;  endfunction
    function automatic int lanes_n(); return (sel == 2) ? 1 : LANES; endfunction
    function automatic int ncand_n(); return (sel == 0) ? 4 : 1;     endfunction
    function automatic longint sat_max();
        return (sel == 1) ? 64'd4095 : 64'hFFFF_FFFF;
    endfunction

    // Total absolute difference of the whole block, clipped at the accumulator ceiling.
    function automatic longint cand_sad(input int c);
        longint s = 0;
        for (int r = 0; r < rows_n(); r++) begin
            for (int l = 0; l < lanes_n(); l++) begin
                int a = int'(cur_mem[c][r][l*8 +: 8]);
                int b = int'(ref_mem[c][r][l*8 +: 8]);
                s += (a > b) ? longint'(a - b) : longint'(b - a);
            end
        end
        return (s > sat_max()) ? sat_max() : s;
    endfunction

    task automatic fill_const(input int c, input int cv, input int rv);
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < LANES; l++) begin
                cur_mem[c][r][l*8 +: 8] = 8'(cv);
                ref_mem[c][r][l*8 +: 8] = 8'(rv);
            end
        end
    endtask

    task automatic fill_random(input int c);
        for (int r = 0; r < ROWS; r++) begin
            cur_mem[c][r] = {$urandom(), $urandom(), $urandom(), $urandom()};
            ref_mem[c][r] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    // Spreads a target SAD over the block, alternating which side is larger.
    task automatic fill_target(input int c, input int target);
        int rem = target;
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < LANES; l++) begin
                int d = (rem > 255) ? 255 : rem;
                rem -= d;
                cur_mem[c][r][l*8 +: 8] = ((l % 2) == 1) ? 8'd0 : 8'(d);
                ref_mem[c][r][l*8 +: 8] = ((l % 2) == 1) ? 8'(d) : 8'd0;
            end
        end
    endtask

    // mode: 0 valid always, 1 valid every other cycle, 2 random valid.
    task automatic feed_cand(input int c, input int mode, input int go_row, input int abort_row);
        int     k = 0;
        int     cyc = 0;
        bit     hs = 1'b0;
        longint s_exp;
        while (1) begin
            @(negedge clk);
            if (hs) k++;
            if (k == abort_row || k == rows_n() || cyc > 3000) break;
            valid   = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
            cur_bus = cur_mem[c][k];
            ref_bus = ref_mem[c][k];
            go      = (k == go_row);
            hs      = valid && obs_ready;
            cyc++;
        end
        valid   = 1'b0;
        go      = 1'b0;
        cur_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
        ref_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
        n_cmp++;
        if (k != rows_n() && k != abort_row) begin
            n_fail++;
            $display("FAIL feed_timeout: beats accepted %0d, required %0d", k, rows_n());
            return;
        end
        if (k == abort_row) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            n_cmp++;
            if ({obs_busy, obs_ready, obs_sv, obs_done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL abort_idle: busy/ready/sv/done=%b required 0000",
                         {obs_busy, obs_ready, obs_sv, obs_done});
            end
            n_cmp++;
            if (obs_sad !== 32'(last_sad_m) || obs_ci !== 8'(last_idx_m)) begin
                n_fail++;
                $display("FAIL abort_keep_last: sad=%0d idx=%0d required sad=%0d idx=%0d",
                         obs_sad, obs_ci, last_sad_m, last_idx_m);
            end
            n_cmp++;
            if (obs_best !== 32'(best_m) || obs_bi !== 8'(bidx_m)) begin
                n_fail++;
                $display("FAIL abort_keep_best: best=%0d idx=%0d required best=%0d idx=%0d",
                         obs_best, obs_bi, best_m, bidx_m);
            end
            $display("sel=%0d cand=%0d aborted at row %0d", sel, c, abort_row);
            return;
        end
        n_cmp++;
        if ({obs_ready, obs_sv} !== 2'b00) begin
            n_fail++;
            $display("FAIL cend_bubble: ready/sv=%b required 00", {obs_ready, obs_sv});
        end
        s_exp = cand_sad(c);
        if (s_exp < best_m) begin
            best_m = s_exp;
            bidx_m = c;
        end
        last_sad_m = s_exp;
        last_idx_m = c;
        @(negedge clk);
        n_cmp++;
        if (obs_sv !== 1'b1) begin
            n_fail++;
            $display("FAIL sad_valid_latency: sad_valid=%b required 1 two edges after last beat", obs_sv);
        end
        n_cmp++;
        if (obs_sad !== 32'(s_exp) || obs_ci !== 8'(c)) begin
            n_fail++;
            $display("FAIL sad_out: sad=%0d idx=%0d required sad=%0d idx=%0d", obs_sad, obs_ci, s_exp, c);
        end
        n_cmp++;
        if (obs_best !== 32'(best_m) || obs_bi !== 8'(bidx_m)) begin
            n_fail++;
            $display("FAIL best: best=%0d idx=%0d required best=%0d idx=%0d", obs_best, obs_bi, best_m, bidx_m);
        end
        n_cmp++;
        if (obs_done !== (c == ncand_n() - 1)) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b required %b", obs_done, (c == ncand_n() - 1));
        end
        $display("sel=%0d cand=%0d sad=%0d cand_idx=%0d best=%0d/%0d done=%b",
                 sel, c, obs_sad, obs_ci, obs_best, obs_bi, obs_done);
    endtask

    task automatic start_search();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n_cmp++;
        if ({obs_busy, obs_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL init_state: busy/ready=%b required 10", {obs_busy, obs_ready});
        end
        best_m = sat_max();
        bidx_m = 0;
    endtask

    task automatic run_search(input int mode, input int go_cand, input int abort_cand, input int abort_row);
        start_search();
        for (int c = 0; c < ncand_n(); c++) begin
            feed_cand(c, mode, (c == go_cand) ? 5 : -1, (c == abort_cand) ? abort_row : -1);
            if (c == abort_cand) return;
        end
        @(negedge clk);
        n_cmp++;
        if ({obs_busy, obs_ready, obs_sv, obs_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_done: busy/ready/sv/done=%b required 0000",
                     {obs_busy, obs_ready, obs_sv, obs_done});
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if ({obs_ready, obs_busy, obs_sv, obs_done} !== 4'b0000 || obs_sad !== 32'd0 || obs_ci !== 8'd0 ||
            obs_best !== 32'(sat_max()) || obs_bi !== 8'd0) begin
            n_fail++;
            $display("FAIL %s sel=%0d: ctl=%b sad=%0d idx=%0d best=%0d bidx=%0d required ctl=0000 sad=0 idx=0 best=%0d bidx=0",
                     tag, sel, {obs_ready, obs_busy, obs_sv, obs_done}, obs_sad, obs_ci, obs_best, obs_bi, sat_max());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_reset_values("reset_state");
        end
    endtask

    task automatic test_single();
        sel = 1;
        fill_const(0, 10, 3);
        run_search(0, -1, -1, -1);
        fill_const(0, 3, 10);
        run_search(0, -1, -1, -1);
    endtask

    task automatic test_toggle();
        sel = 1;
        fill_const(0, 10, 3);
        run_search(1, -1, -1, -1);
    endtask

    task automatic test_saturate();
        sel = 1;
        fill_const(0, 255, 0);
        run_search(0, -1, -1, -1);
    endtask

    task automatic test_ties();
        sel = 0;
        fill_target(0, 500);
        fill_target(1, 200);
        fill_target(2, 200);
        fill_target(3, 900);
        run_search(0, -1, -1, -1);
    endtask

    task automatic test_random();
        sel = 0;
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 4; c++) fill_random(c);
            run_search(2, -1, -1, -1);
        end
    endtask

    task automatic test_go_mid();
        sel = 0;
        fill_target(0, 500);
        fill_target(1, 200);
        fill_target(2, 200);
        fill_target(3, 900);
        run_search(2, 1, -1, -1);
    endtask

    task automatic test_abort();
        bit seen;
        sel = 0;
        for (int c = 0; c < 4; c++) fill_random(c);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) run_search(0, -1, 2, 7);
            else           run_search(2, -1, 1, ROWS);
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (obs_sv || obs_done || obs_busy) seen = 1'b1;
            end
            n_cmp++;
            if (seen) begin
                n_fail++;
                $display("FAIL abort_quiet: activity after abort=%b required 0", seen);
            end
        end
    endtask

    task automatic test_rst_mid();
        sel = 0;
        for (int c = 0; c < 4; c++) fill_random(c);
        start_search();
        feed_cand(0, 0, -1, -1);
        valid   = 1'b1;
        cur_bus = cur_mem[1][0];
        ref_bus = ref_mem[1][0];
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        check_reset_values("rst_mid");
        last_sad_m = 0;
        last_idx_m = 0;
    endtask

    task automatic test_back_to_back();
        sel = 2;
        cur_mem[0][0] = '0;
        ref_mem[0][0] = 128'(8'd255);
        start_search();
        feed_cand(0, 0, -1, -1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n_cmp++;
        if ({obs_busy, obs_ready} !== 2'b10 || obs_best !== 32'd255) begin
            n_fail++;
            $display("FAIL b2b_init: busy/ready=%b best=%0d required 10 best=255", {obs_busy, obs_ready}, obs_best);
        end
        @(negedge clk);
        n_cmp++;
        if (obs_best !== 32'hFFFF_FFFF || obs_bi !== 8'd0 || obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_best_reinit: best=%0h idx=%0d ready=%b required ffffffff 0 1", obs_best, obs_bi, obs_ready);
        end
        best_m = sat_max();
        bidx_m = 0;
        cur_mem[0][0] = 128'(8'd5);
        ref_mem[0][0] = '0;
        feed_cand(0, 0, -1, -1);
    endtask

    initial begin
        best_m = 0; bidx_m = 0; last_sad_m = 0; last_idx_m = 0;
        test_reset();
        test_single();
        test_toggle();
        test_saturate();
        test_ties();
        test_random();
        test_go_mid();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
